alu_rr_sched: RTL and testbench

//  Schedules one shared 32-bit ALU (add/sub/and/or/not/slt) between two requesters with a round-robin policy.

---
 rtl/alu_rr_sched.sv | 158 +++++++++++++++
 tb/tb_alu_rr_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler for one shared ALU between two requesters.
// Latches the winning request, holds it on the ALU for EXEC_CYCLES, then returns a tagged, registered response.
module alu_rr_sched #(
  parameter int W           = 32,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [W-1:0]     req0_a_i,
  input  logic [W-1:0]     req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [W-1:0]     req1_a_i,
  input  logic [W-1:0]     req1_b_i,
  output logic [2:0]       alu_op_o,
  output logic [W-1:0]     alu_a_o,
  output logic [W-1:0]     alu_b_o,
  input  logic [W-1:0]     alu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [W-1:0]     rsp_result_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt0_o,
  output logic [CNT_W-1:0] done_cnt1_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]       EXEC_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic             last_grant_q;
  logic             id_q;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [3:0]       cnt_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [W-1:0]     rsp_result_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic [CNT_W-1:0] done_cnt0_q;
  logic [CNT_W-1:0] done_cnt1_q;

  logic             sel_valid;
  logic             sel_id;
  logic             op_illegal;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    sel_valid = req0_valid_i | req1_valid_i;
    sel_id    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      sel_id = ~last_grant_q;
    end else if (req1_valid_i) begin
      sel_id = 1'b1;
    end else begin
      sel_id = 1'b0;
    end
  end

  assign op_illegal   = (op_q[2:1] == 2'b11);
  assign req0_ready_o = (state_q == IDLE) && sel_valid && !sel_id;
  assign req1_ready_o = (state_q == IDLE) && sel_valid && sel_id;

  // Main FSM: capture request, run the ALU for EXEC_CYCLES, hold the response until taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_cnt0_q  <= '0;
      done_cnt1_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            id_q         <= sel_id;
            last_grant_q <= sel_id;
            op_q         <= sel_id ? req1_op_i : req0_op_i;
            a_q          <= sel_id ? req1_a_i  : req0_a_i;
            b_q          <= sel_id ? req1_b_i  : req0_b_i;
            cnt_q        <= EXEC_LOAD;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end else begin
            state_q      <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            // Illegal ops still take the full execution time so latency is op-independent.
            rsp_result_q <= op_illegal ? '0 : alu_result_i;
            rsp_err_q    <= op_illegal;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q        <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            if (id_q) begin
              done_cnt1_q <= done_cnt1_q + CNT_ONE;
            end else begin
              done_cnt0_q <= done_cnt0_q + CNT_ONE;
            end
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign done_cnt0_o  = done_cnt0_q;
  assign done_cnt1_o  = done_cnt1_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: vector table, corner sequences, random traffic vs. a transaction model.
module tb_alu_rr_sched;
  localparam int W     = 32;
  localparam int EXEC  = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op, alu_op;
  logic [W-1:0]     req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0]     rsp_result;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model
  int          m_cyc = 0;
  int          m_due = 0;
  bit          m_pend = 1'b0;
  bit          m_last = 1'b1;
  bit          m_id;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  bit          m_err;
  logic [15:0] m_cnt [2];
  int          grants[$];

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  alu_rr_sched #(.W(W), .EXEC_CYCLES(EXEC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_err_o(rsp_err), .busy_o(busy),
    .done_cnt0_o(done_cnt0), .done_cnt1_o(done_cnt1)
  );

  function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      3'd5:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU stand-in; garbage on illegal ops so the forced zero is observable.
  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_last = 1'b1;
    m_cnt[0] = 16'd0;
    m_cnt[1] = 16'd0;
  endtask

  task automatic set_req(int n, bit v, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic tick();
    bit e_r0, e_r1, e_rv, take;
    #1;
    e_r0 = !m_pend && req0_valid && (!req1_valid || m_last);
    e_r1 = !m_pend && req1_valid && (!req0_valid || !m_last);
    e_rv = m_pend && (m_cyc >= m_due);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("busy", busy, m_pend);
    chk("rsp_valid", rsp_valid, e_rv);
    if (m_pend) begin
      chk("alu_op", alu_op, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
    if (e_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_err", rsp_err, m_err);
    end
    chk("done_cnt0", done_cnt0, m_cnt[0]);
    chk("done_cnt1", done_cnt1, m_cnt[1]);
    take = e_rv && rsp_ready;
    @(posedge clk);
    m_cyc++;
    if (rst) begin
      model_reset();
    end else begin
      if (take) begin
        m_pend = 1'b0;
        m_cnt[m_id] = m_cnt[m_id] + 16'd1;
      end
      if (e_r0 || e_r1) begin
        m_id   = e_r1;
        m_op   = e_r1 ? req1_op : req0_op;
        m_a    = e_r1 ? req1_a : req0_a;
        m_b    = e_r1 ? req1_b : req0_b;
        m_err  = (m_op == 3'd6) || (m_op == 3'd7);
        m_res  = m_err ? 32'd0 : ref_alu(m_op, m_a, m_b);
        m_due  = m_cyc + EXEC;
        m_pend = 1'b1;
        m_last = e_r1;
        grants.push_back(int'(e_r1));
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    while (m_pend && n < 40) begin
      tick();
      n++;
    end
    chk("drain_timeout", m_pend, 1'b0);
  endtask

  initial begin
    int n;
    logic [15:0] c0, c1;
    tbl[0] = '{1'b0, 3'd0, 32'd5,          32'd1,          32'd6,          1'b0};
    tbl[1] = '{1'b0, 3'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{1'b1, 3'd2, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0};
    tbl[3] = '{1'b0, 3'd3, 32'h8000_0001,  32'h0000_0010,  32'h8000_0011,  1'b0};
    tbl[4] = '{1'b1, 3'd4, 32'h0000_FFFF,  32'd7,          32'hFFFF_0000,  1'b0};
    tbl[5] = '{1'b0, 3'd5, 32'd3,          32'd7,          32'd1,          1'b0};
    tbl[6] = '{1'b1, 3'd5, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[7] = '{1'b0, 3'd0, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0};
    tbl[8] = '{1'b0, 3'd6, 32'd9,          32'd9,          32'd0,          1'b1};
    tbl[9] = '{1'b1, 3'd7, 32'd1,          32'd2,          32'd0,          1'b1};

    rst = 1'b1;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    model_reset();
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Vector table: one request at a time, latency and result checked against constants.
    for (int i = 0; i < 10; i++) begin
      set_req(int'(tbl[i].id), 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      tick();
      set_req(int'(tbl[i].id), 1'b0, 3'd0, 32'd0, 32'd0);
      n = 0;
      while (!rsp_valid && n < 20) begin
        tick();
        n++;
      end
      chk("tbl_latency", n, EXEC);
      chk("tbl_id", rsp_id, tbl[i].id);
      chk("tbl_result", rsp_result, tbl[i].res);
      chk("tbl_err", rsp_err, tbl[i].err);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (i == 0) chk("t1_done_cnt0", done_cnt0, 16'd1);
    end

    // Both requesters valid every cycle: grants must alternate starting at 0.
    grants.delete();
    c0 = m_cnt[0];
    c1 = m_cnt[1];
    rsp_ready = 1'b1;
    n = 0;
    while (grants.size() < 4 && n < 60) begin
      set_req(0, 1'b1, 3'd0, 32'(n), 32'd100);
      set_req(1, 1'b1, 3'd1, 32'd1000, 32'(n));
      tick();
      n++;
    end
    drain();
    chk("t3_ngrants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("t3_grant", grants[i], i % 2);
    chk("t3_cnt0", done_cnt0, c0 + 16'd2);
    chk("t3_cnt1", done_cnt1, c1 + 16'd2);

    // Consumer stalls: response held, new request not accepted.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'd0, 32'd10, 32'd20);
    tick();
    set_req(0, 1'b1, 3'd1, 32'd77, 32'd7);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_req0_ready", req0_ready, 1'b0);
      chk("t5_busy", busy, 1'b1);
      chk("t5_result", rsp_result, 32'd30);
    end
    drain();

    // Reset during execution drops the request and restores the tie-break to requester 0.
    set_req(0, 1'b1, 3'd2, 32'hFF, 32'h0F);
    tick();
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_alu_op", alu_op, 3'd0);
    chk("t6_alu_a", alu_a, 32'd0);
    chk("t6_done_cnt0", done_cnt0, 16'd0);
    model_reset();
    tick();
    rst = 1'b0;
    grants.delete();
    set_req(0, 1'b1, 3'd0, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'd0, 32'd2, 32'd2);
    tick();
    chk("t6_tie_grant", (grants.size() == 1) ? grants[0] : -1, 0);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_req(0, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom_range(0, 9));
      set_req(1, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
              $urandom, ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
